xsystem86_mem_arbiter: RTL and testbench

XSYSTEM86_MEM_ARBITER -- requirements
Module: xsystem86_mem_arbiter

---
 rtl/xsystem86_mem_arbiter_if.sv | 34 +++
 rtl/xsystem86_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_xsystem86_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xsystem86_mem_arbiter_if.sv
// rtl/xsystem86_mem_arbiter_if.sv - requester and external memory bus bundle for xsystem86_mem_arbiter
interface xsystem86_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 21
);
  // requester side: one lane per port, port n at slice n
  logic [3:0]              req;
  logic [3:0]              we;
  logic [4*ADDR_WIDTH-1:0] addr;
  logic [31:0]             wdata;
  logic [3:0]              ack;
  logic [7:0]              rdata;
  logic                    busy;

  // shared asynchronous SRAM/flash port
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [7:0]              mem_dq_o;
  logic [7:0]              mem_dq_i;
  logic                    mem_dq_oe;
  logic                    mem_ce_n;
  logic                    mem_oe_n;
  logic                    mem_we_n;

  // arbiter view
  modport slave (
    input  req, we, addr, wdata, mem_dq_i,
    output ack, rdata, busy, mem_addr, mem_dq_o, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n
  );

  // requesters plus memory device view
  modport master (
    output req, we, addr, wdata, mem_dq_i,
    input  ack, rdata, busy, mem_addr, mem_dq_o, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/xsystem86_mem_arbiter.sv
// rtl/xsystem86_mem_arbiter.sv - 4-port round-robin arbiter onto one async memory; writes enabled by XSYSTEM86_MEM_ARB_WRITE_EN
module xsystem86_mem_arbiter #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_WIDTH  = 21
) (
  input logic                    clk_48m,
  input logic                    rst,
  xsystem86_mem_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            ptr;
  logic [1:0]            grant;
  logic [1:0]            grant_nxt;
  logic [1:0]            idx;
  logic                  grant_vld;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_we;
  logic [7:0]            rdata_q;
  logic [3:0]            ack_c;
  logic                  ce_n_c;
  logic                  oe_n_c;
  logic                  we_n_c;
  logic                  dq_oe_c;
  logic [7:0]            dq_o_c;

  // round-robin pick: scan from the far end so the port nearest the pointer wins
  always_comb begin
    grant_vld = 1'b0;
    grant_nxt = ptr;
    idx       = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bus.req[idx]) begin
        grant_vld = 1'b1;
        grant_nxt = idx;
      end
    end
  end

  // state register; async reset aborts any transaction in flight
  always_ff @(posedge clk_48m or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and memory strobes, all decoded from the current state
  always_comb begin
    state_nxt = state;
    ack_c     = 4'b0000;
    ce_n_c    = 1'b1;
    oe_n_c    = 1'b1;
    we_n_c    = 1'b1;
    dq_oe_c   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) state_nxt = ACCESS;
      end
      ACCESS: begin
        ce_n_c = 1'b0;
        if (lat_we) begin
          we_n_c  = 1'b0;
          dq_oe_c = 1'b1;
        end else begin
          oe_n_c = 1'b0;
        end
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        ack_c[grant] = 1'b1;
        dq_oe_c      = lat_we;   // keep driving write data one cycle past we_n rising
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // transaction datapath: latch the winner, count wait states, capture read data on exit
  always_ff @(posedge clk_48m or posedge rst) begin
    if (rst) begin
      ptr      <= 2'd0;
      grant    <= 2'd0;
      cnt      <= 4'd0;
      lat_addr <= '0;
      rdata_q  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            grant    <= grant_nxt;
            ptr      <= grant_nxt + 2'd1;
            cnt      <= WAIT_LOAD;
            lat_addr <= bus.addr[grant_nxt*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!lat_we) begin
            rdata_q <= bus.mem_dq_i;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef XSYSTEM86_MEM_ARB_WRITE_EN
  logic [7:0] lat_wdata;

  // write flag and data for the granted port, frozen for the whole transaction
  always_ff @(posedge clk_48m or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_wdata <= 8'h00;
    end else if (state == IDLE && grant_vld) begin
      lat_we    <= bus.we[grant_nxt];
      lat_wdata <= bus.wdata[grant_nxt*8 +: 8];
    end
  end

  assign dq_o_c = lat_wdata;
`else
  // read-only build: every access is a read and the data bus is never driven
  logic unused_write_inputs;
  assign unused_write_inputs = ^{bus.we, bus.wdata};
  assign lat_we = 1'b0;
  assign dq_o_c = 8'h00;
`endif

  assign bus.ack       = ack_c;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_dq_o  = dq_o_c;
  assign bus.mem_dq_oe = dq_oe_c;
  assign bus.mem_ce_n  = ce_n_c;
  assign bus.mem_oe_n  = oe_n_c;
  assign bus.mem_we_n  = we_n_c;

endmodule

// File: tb/tb_xsystem86_mem_arbiter.sv
// tb/tb_xsystem86_mem_arbiter.sv - directed bench for xsystem86_mem_arbiter (WAIT_STATES 2 and 0 instances)
module tb_xsystem86_mem_arbiter;
  localparam int AW = 21;

  logic clk_48m = 1'b0;
  logic rst     = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  xsystem86_mem_arbiter_if #(.ADDR_WIDTH(AW)) b2 ();
  xsystem86_mem_arbiter_if #(.ADDR_WIDTH(AW)) b0 ();

  xsystem86_mem_arbiter #(.WAIT_STATES(2), .ADDR_WIDTH(AW)) u_dut (
    .clk_48m (clk_48m),
    .rst     (rst),
    .bus     (b2)
  );

  xsystem86_mem_arbiter #(.WAIT_STATES(0), .ADDR_WIDTH(AW)) u_dut_ws0 (
    .clk_48m (clk_48m),
    .rst     (rst),
    .bus     (b0)
  );

  always #10 clk_48m = ~clk_48m;

  task automatic step();
    @(posedge clk_48m);
    #1;
  endtask

  task automatic test_reset();
    logic [45:0] exp_v;
    exp_v = {4'b0000, 8'h00, 1'b0, 21'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    repeat (2) step();
    n_checks++;
    if ({b2.ack, b2.rdata, b2.busy, b2.mem_addr, b2.mem_dq_o, b2.mem_dq_oe, b2.mem_ce_n, b2.mem_oe_n, b2.mem_we_n} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_ws2 got %h exp %h", {b2.ack, b2.rdata, b2.busy, b2.mem_addr, b2.mem_dq_o, b2.mem_dq_oe, b2.mem_ce_n, b2.mem_oe_n, b2.mem_we_n}, exp_v);
    end
    n_checks++;
    if ({b0.ack, b0.rdata, b0.busy, b0.mem_addr, b0.mem_dq_o, b0.mem_dq_oe, b0.mem_ce_n, b0.mem_oe_n, b0.mem_we_n} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_ws0 got %h exp %h", {b0.ack, b0.rdata, b0.busy, b0.mem_addr, b0.mem_dq_o, b0.mem_dq_oe, b0.mem_ce_n, b0.mem_oe_n, b0.mem_we_n}, exp_v);
    end
    rst = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({b2.busy, b2.ack, b2.mem_ce_n} !== 6'b0_0000_1) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b exp %b", {b2.busy, b2.ack, b2.mem_ce_n}, 6'b0_0000_1);
    end
  endtask

  // port0 read, dq_i only becomes A5 just before the capturing edge
  task automatic test_read();
    logic [7:0] exp_v;
    b2.addr[0 +: AW] = 21'h01234;
    b2.mem_dq_i = 8'h3C;
    b2.req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_48m);
      exp_v = (c >= 1 && c <= 3) ? 8'b1_0_0_1_0000 : (c == 4) ? 8'b1_1_1_1_0001 : 8'b0_1_1_1_0000;
      n_checks++;
      if ({b2.busy, b2.mem_ce_n, b2.mem_oe_n, b2.mem_we_n, b2.ack} !== exp_v) begin
        n_fail++;
        $display("FAIL read_ctrl c=%0d got %b exp %b", c, {b2.busy, b2.mem_ce_n, b2.mem_oe_n, b2.mem_we_n, b2.ack}, exp_v);
      end
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if (b2.mem_addr !== 21'h01234) begin
          n_fail++;
          $display("FAIL read_addr c=%0d got %h exp %h", c, b2.mem_addr, 21'h01234);
        end
      end
      if (c >= 4) begin
        n_checks++;
        if (b2.rdata !== 8'hA5) begin
          n_fail++;
          $display("FAIL read_rdata c=%0d got %h exp %h", c, b2.rdata, 8'hA5);
        end
      end
      if (c == 3) b2.mem_dq_i = 8'hA5;
      if (c == 4) b2.mem_dq_i = 8'hFF;
      step();
      if (c == 4) b2.req[0] = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int gap;
    int ce_low;
    logic [3:0] drop;
    logic seen;
    gap = 0; ce_low = 0; drop = 4'b0000; seen = 1'b0;
    rst = 1'b1;
    for (int p = 0; p < 4; p++) b2.addr[p*AW +: AW] = 21'(32'h100 * (p + 1));
    b2.req = 4'b1111;
    step();
    rst = 1'b0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk_48m);
      if (b2.ack != 4'b0000) begin
        n_checks++;
        if ($countones(b2.ack) != 1) begin
          n_fail++;
          $display("FAIL rr_onehot got %b exp one bit", b2.ack);
        end
        for (int p = 0; p < 4; p++) if (b2.ack[p]) order.push_back(p);
        drop = b2.ack;
        seen = 1'b1;
      end else if (seen && !b2.busy) begin
        gap++;
      end
      if (!b2.mem_ce_n) ce_low++;
      step();
      b2.req = b2.req & ~drop;
      drop = 4'b0000;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= order.size()) begin
        n_fail++;
        $display("FAIL rr_order slot %0d got none exp port %0d", i, i);
      end else if (order[i] != i) begin
        n_fail++;
        $display("FAIL rr_order slot %0d got port %0d exp port %0d", i, order[i], i);
      end
    end
    n_checks++;
    if (gap != 3) begin
      n_fail++;
      $display("FAIL rr_idle_gaps got %0d exp 3", gap);
    end
    n_checks++;
    if (ce_low != 12) begin
      n_fail++;
      $display("FAIL rr_access_cycles got %0d exp 12", ce_low);
    end
  endtask

  task automatic test_write();
    logic [8:0] exp_v;
    b2.addr[3*AW +: AW] = 21'h1FFFF;
    b2.wdata[31:24] = 8'h5A;
    b2.we = 4'b1000;
    b2.req = 4'b1000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_48m);
`ifdef XSYSTEM86_MEM_ARB_WRITE_EN
      exp_v = (c >= 1 && c <= 3) ? 9'b1_0_1_0_1_0000 : (c == 4) ? 9'b1_1_1_1_1_1000 : 9'b0_1_1_1_0_0000;
`else
      exp_v = (c >= 1 && c <= 3) ? 9'b1_0_0_1_0_0000 : (c == 4) ? 9'b1_1_1_1_0_1000 : 9'b0_1_1_1_0_0000;
`endif
      n_checks++;
      if ({b2.busy, b2.mem_ce_n, b2.mem_oe_n, b2.mem_we_n, b2.mem_dq_oe, b2.ack} !== exp_v) begin
        n_fail++;
        $display("FAIL write_ctrl c=%0d got %b exp %b", c, {b2.busy, b2.mem_ce_n, b2.mem_oe_n, b2.mem_we_n, b2.mem_dq_oe, b2.ack}, exp_v);
      end
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if (b2.mem_addr !== 21'h1FFFF) begin
          n_fail++;
          $display("FAIL write_addr c=%0d got %h exp %h", c, b2.mem_addr, 21'h1FFFF);
        end
      end
      if (c >= 1 && c <= 4) begin
        n_checks++;
`ifdef XSYSTEM86_MEM_ARB_WRITE_EN
        if (b2.mem_dq_o !== 8'h5A) begin
          n_fail++;
          $display("FAIL write_dq c=%0d got %h exp %h", c, b2.mem_dq_o, 8'h5A);
        end
`else
        if (b2.mem_dq_o !== 8'h00) begin
          n_fail++;
          $display("FAIL write_dq c=%0d got %h exp %h", c, b2.mem_dq_o, 8'h00);
        end
`endif
      end
      step();
      if (c == 4) begin
        b2.req[3] = 1'b0;
        b2.we = 4'b0000;
      end
    end
  endtask

  // port2 raises and drops req while port0 is in flight: never acked
  task automatic test_drop();
    int acks0;
    int acks2;
    logic drop0;
    acks0 = 0; acks2 = 0; drop0 = 1'b0;
    b2.req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_48m);
      if (b2.ack[0]) begin
        acks0++;
        drop0 = 1'b1;
      end
      if (b2.ack[2]) acks2++;
      step();
      if (c == 1) b2.req[2] = 1'b1;
      if (c == 2) b2.req[2] = 1'b0;
      if (drop0) b2.req[0] = 1'b0;
    end
    n_checks++;
    if (acks0 != 1 || acks2 != 0) begin
      n_fail++;
      $display("FAIL drop_acks got port0=%0d port2=%0d exp port0=1 port2=0", acks0, acks2);
    end
  endtask

  task automatic test_reset_abort();
    logic [3:0] first;
    logic [3:0] second;
    logic [3:0] drop;
    int nacks;
    int early_acks;
    first = 4'b0000; second = 4'b0000; drop = 4'b0000; nacks = 0; early_acks = 0;
    b2.addr[1*AW +: AW] = 21'h0ABCD;
    b2.addr[2*AW +: AW] = 21'h0BEEF;
    b2.req = 4'b0010;
    @(negedge clk_48m);
    step();
    @(negedge clk_48m);
    n_checks++;
    if ({b2.mem_ce_n, b2.mem_addr} !== {1'b0, 21'h0ABCD}) begin
      n_fail++;
      $display("FAIL abort_in_access got ce_n=%b addr=%h exp ce_n=0 addr=0abcd", b2.mem_ce_n, b2.mem_addr);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({b2.ack, b2.rdata, b2.busy, b2.mem_addr, b2.mem_dq_o, b2.mem_dq_oe, b2.mem_ce_n, b2.mem_oe_n, b2.mem_we_n}
        !== {4'b0000, 8'h00, 1'b0, 21'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_outputs got ack=%b rdata=%h busy=%b addr=%h ce_n=%b oe_n=%b", b2.ack, b2.rdata, b2.busy, b2.mem_addr, b2.mem_ce_n, b2.mem_oe_n);
    end
    b2.req = 4'b0110;
    step();
    if (b2.ack != 4'b0000) early_acks++;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_48m);
      if (b2.ack != 4'b0000) begin
        if (nacks == 0) first = b2.ack;
        else if (nacks == 1) second = b2.ack;
        nacks++;
        drop = b2.ack;
      end
      step();
      b2.req = b2.req & ~drop;
      drop = 4'b0000;
    end
    n_checks++;
    if (early_acks != 0) begin
      n_fail++;
      $display("FAIL abort_no_ack got %0d acks exp 0", early_acks);
    end
    n_checks++;
    if ({first, second} !== 8'b0010_0100 || nacks != 2) begin
      n_fail++;
      $display("FAIL abort_regrant got first=%b second=%b count=%0d exp 0010 0100 2", first, second, nacks);
    end
  endtask

  // WAIT_STATES=0: port2 holds req, ack every 3rd cycle, addr edits mid-access ignored
  task automatic test_back_to_back();
    logic [3:0] exp_ack;
    b0.addr[2*AW +: AW] = 21'h00100;
    b0.mem_dq_i = 8'h77;
    b0.req = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_48m);
      exp_ack = (c % 3 == 2) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (b0.ack !== exp_ack) begin
        n_fail++;
        $display("FAIL b2b_ack c=%0d got %b exp %b", c, b0.ack, exp_ack);
      end
      if (exp_ack != 4'b0000) begin
        n_checks++;
        if (b0.rdata !== 8'h77) begin
          n_fail++;
          $display("FAIL b2b_rdata c=%0d got %h exp 77", c, b0.rdata);
        end
      end
      if (c == 1 || c == 4) begin
        b0.addr[2*AW +: AW] = (c == 1) ? 21'h00200 : 21'h00300;
        #1;
        n_checks++;
        if (b0.mem_addr !== ((c == 1) ? 21'h00100 : 21'h00200)) begin
          n_fail++;
          $display("FAIL b2b_addr_hold c=%0d got %h exp %h", c, b0.mem_addr, (c == 1) ? 21'h00100 : 21'h00200);
        end
      end
      step();
    end
    b0.req = 4'b0000;
    repeat (3) step();
  endtask

  initial begin
    b2.req = 4'b0000; b2.we = 4'b0000; b2.addr = '0; b2.wdata = 32'h0; b2.mem_dq_i = 8'h00;
    b0.req = 4'b0000; b0.we = 4'b0000; b0.addr = '0; b0.wdata = 32'h0; b0.mem_dq_i = 8'h00;
    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_drop();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
